// File: rtl/aho_pkg.sv
// Shared constants and state encoding for the AHO flag stream blocks.
//   AHO_CW      : default result/counter width (also used by the aho generator)
//   AHO_WINDOW  : default samples per window
//   rx_state_e  : result-holding state of the window receiver
package aho_pkg;

  localparam int unsigned AHO_CW     = 16;
  localparam int unsigned AHO_WINDOW = 1000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rx_state_e;

endpackage : aho_pkg

// File: rtl/aho_run_tracker.sv
// Saturating hit / run / max-run accumulators for one window of AHO samples.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : sample enable; accumulators freeze when low
//   aho       : current sample
//   wend      : current enabled sample is the last of its window
//   hits_c    : hit count including the current sample (combinational)
//   maxrun_c  : longest run including the current sample (combinational)
module aho_run_tracker
  import aho_pkg::*;
#(
  parameter int unsigned CW = AHO_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          aho,
  input  logic          wend,
  output logic [CW-1:0] hits_c,
  output logic [CW-1:0] maxrun_c
);

  localparam logic [CW-1:0] SAT = '1;

  logic [CW-1:0] hit_q, run_q, max_q;
  logic [CW-1:0] hit_n, run_n, max_n;

  // Values after folding in the current sample; all saturate at SAT.
  always_comb begin
    hit_n = hit_q;
    run_n = '0;
    if (aho) begin
      hit_n = (hit_q == SAT) ? hit_q : hit_q + CW'(1);
      run_n = (run_q == SAT) ? run_q : run_q + CW'(1);
    end
    max_n = (run_n > max_q) ? run_n : max_q;
  end

  // Accumulators advance only on enabled samples and restart after window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else if (en) begin
      if (wend) begin
        hit_q <= '0;
        run_q <= '0;
        max_q <= '0;
      end else begin
        hit_q <= hit_n;
        run_q <= run_n;
        max_q <= max_n;
      end
    end
  end

  assign hits_c   = hit_n;
  assign maxrun_c = max_n;

endmodule : aho_run_tracker

// File: rtl/aho_window_rx.sv
// Windowed receiver for the AHO flag stream: per WINDOW enabled samples it
// reports the hit count and the longest run over a valid/ready handshake.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : sample enable
//   aho       : flag stream input
//   hits      : hit count of the last completed window
//   maxrun    : longest run of 1s in that window
//   valid     : hits/maxrun hold an unconsumed result
//   ready     : downstream accepts the result
//   ovf       : sticky, a window completed while a result was pending
module aho_window_rx
  import aho_pkg::*;
#(
  parameter int unsigned WINDOW = AHO_WINDOW,
  parameter int unsigned CW     = AHO_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          aho,
  output logic [CW-1:0] hits,
  output logic [CW-1:0] maxrun,
  output logic          valid,
  input  logic          ready,
  output logic          ovf
);

  localparam int unsigned IW = $clog2(WINDOW);

  logic [IW-1:0] idx_q;
  logic          wend;
  logic [CW-1:0] hits_c, maxrun_c;
  rx_state_e     state_q, state_d;
  logic          load, ovf_set;

  assign wend = en && (idx_q == IW'(WINDOW - 1));

  // Sample index within the current window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= wend ? '0 : idx_q + IW'(1);
    end
  end

  aho_run_tracker #(.CW(CW)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .aho      (aho),
    .wend     (wend),
    .hits_c   (hits_c),
    .maxrun_c (maxrun_c)
  );

  // Output FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state; a window end while full is taken only if the old result leaves now.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (wend) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (wend) begin
          if (ready) load    = 1'b1;
          else       ovf_set = 1'b1;
        end else if (ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Result registers and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits   <= '0;
      maxrun <= '0;
      ovf    <= 1'b0;
    end else begin
      if (load) begin
        hits   <= hits_c;
        maxrun <= maxrun_c;
      end
      if (ovf_set) ovf <= 1'b1;
    end
  end

  assign valid = (state_q == ST_FULL);

endmodule : aho_window_rx

// File: tb/tb_aho_window_rx.sv
// Directed, table-driven bench for aho_window_rx with WINDOW=8, CW=8.
module tb_aho_window_rx;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned CW     = 8;

  logic          clk = 1'b0;
  logic          rst, en, aho, ready;
  logic [CW-1:0] hits, maxrun;
  logic          valid, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          en;
    logic          aho;
    logic          ready;
    logic          valid;
    logic [CW-1:0] hits;
    logic [CW-1:0] maxrun;
    logic          ovf;
    string         name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  aho_window_rx #(.WINDOW(WINDOW), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .aho    (aho),
    .hits   (hits),
    .maxrun (maxrun),
    .valid  (valid),
    .ready  (ready),
    .ovf    (ovf)
  );

  function automatic void add(string nm, logic r, logic e, logic a, logic rd,
                              logic ev, int eh, int em, logic eo);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.aho = a; v.ready = rd;
    v.valid = ev; v.hits = CW'(eh); v.maxrun = CW'(em); v.ovf = eo;
    vecs.push_back(v);
  endfunction

  initial begin
    int p1[8];
    int p2[8];
    int n;
    p1 = '{1, 1, 0, 1, 1, 1, 0, 0};
    p2 = '{1, 0, 1, 0, 1, 0, 1, 0};
    rst = 1'b1; en = 1'b0; aho = 1'b0; ready = 1'b0;

    // Reset, then idle with en=0
    add("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    add("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    // Constant 1s, ready high: one pulse per window
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 8; i++)
        add("ones", 0, 1, 1, 1, i == 7, (w == 0 && i < 7) ? 0 : 8,
            (w == 0 && i < 7) ? 0 : 8, 0);
    // Pattern 11011100
    for (int i = 0; i < 8; i++)
      add("pat", 0, 1, p1[i][0], 1, i == 7, i == 7 ? 5 : 8, i == 7 ? 3 : 8, 0);
    // Same pattern with an en=0 gap after the 4th sample
    for (int i = 0; i < 4; i++) add("gap", 0, 1, p1[i][0], 1, 0, 5, 3, 0);
    for (int i = 0; i < 3; i++) add("gap_off", 0, 0, 0, 1, 0, 5, 3, 0);
    for (int i = 4; i < 8; i++) add("gap", 0, 1, p1[i][0], 1, i == 7, 5, 3, 0);
    // Overflow: drain, then two windows with ready low
    add("drain", 0, 0, 0, 1, 0, 5, 3, 0);
    for (int i = 0; i < 8; i++)
      add("ovf_a", 0, 1, 1, 0, i == 7, i == 7 ? 8 : 5, i == 7 ? 8 : 3, 0);
    for (int i = 0; i < 8; i++) add("ovf_b", 0, 1, 0, 0, 1, 8, 8, i == 7);
    add("ovf_take", 0, 0, 0, 1, 0, 8, 8, 1);
    add("ovf_stick", 0, 0, 0, 0, 0, 8, 8, 1);
    // Back-to-back: ready rises exactly on the next window end
    add("b2b_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add("b2b_a", 0, 1, 1, 0, i == 7, i == 7 ? 8 : 0, i == 7 ? 8 : 0, 0);
    for (int i = 0; i < 8; i++)
      add("b2b_b", 0, 1, p2[i][0], i == 7, 1, i == 7 ? 4 : 8, i == 7 ? 1 : 8, 0);
    add("b2b_take", 0, 0, 0, 1, 0, 4, 1, 0);
    // Reset in the middle of a window
    for (int i = 0; i < 5; i++) add("mid_pre", 0, 1, 1, 1, 0, 4, 1, 0);
    add("mid_rst", 1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add("mid_post", 0, 1, 0, 1, i == 7, 0, 0, 0);
    add("mid_take", 0, 0, 0, 1, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst; en = vecs[k].en; aho = vecs[k].aho; ready = vecs[k].ready;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== vecs[k].valid || hits !== vecs[k].hits ||
          maxrun !== vecs[k].maxrun || ovf !== vecs[k].ovf) begin
        errors++;
        $display("FAIL %s row %0d: got valid=%b hits=%0d maxrun=%0d ovf=%b, want valid=%b hits=%0d maxrun=%0d ovf=%b",
                 vecs[k].name, k, valid, hits, maxrun, ovf,
                 vecs[k].valid, vecs[k].hits, vecs[k].maxrun, vecs[k].ovf);
      end
    end

    // First result after reset arrives on the 8th enabled edge
    @(negedge clk);
    rst = 1'b1; en = 1'b0; aho = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; aho = 1'b1; ready = 1'b1;
    n = 0;
    while (valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (valid !== 1'b1 || n != 8) begin
      errors++;
      $display("FAIL latency: got %0d edges valid=%b, want 8 edges valid=1", n, valid);
    end
    checks++;
    if (hits !== CW'(8) || maxrun !== CW'(8) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: got hits=%0d maxrun=%0d ovf=%b, want 8 8 0",
               hits, maxrun, ovf);
    end

    // Held result drops one edge later with ready high and no window end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || hits !== CW'(8)) begin
      errors++;
      $display("FAIL consume: got valid=%b hits=%0d, want valid=0 hits=8", valid, hits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_aho_window_rx
